brick_map: RTL and testbench
============================

# brick_map

Storage and collision-resolution stage for the Breakout brick field, directly upstream of the per-row brick display decode. Holds one alive bit per brick, rebuilds the field at reset and on level load, and services ball-collision requests with a valid/ack handshake. It clears a hit brick and tracks how many bricks remain. It also presents the 8-bit brick vector for the row the display is drawing.

## Interface

Parameters
- NUM_ROWS, 8, number of brick rows
- NUM_COLS, 8, bricks per row; width of `bricks`
- CNT_W, 7, width of `bricks_left`; must hold NUM_ROWS*NUM_COLS

Ports
- clk  input  1  system clock; the only clock
- rst  input  1  synchronous, active-high reset
- load_level  input  1  one-cycle pulse; refill the whole field
- hit_valid  input  1  collision request; held until `hit_ack`
- hit_row  input  4  brick row of the request
- hit_col  input  4  brick column of the request
- hit_ack  output  1  one-cycle pulse; request resolved
- hit_result  output  1  valid with `hit_ack`; 1 = a live brick was destroyed
- rd_row  input  4  row the display requests
- bricks  output  NUM_COLS  alive bits of `rd_row`; bit i = column i
- bricks_left  output  CNT_W  live brick count
- all_clear  output  1  field empty, outside INIT
- busy  output  1  high in INIT

## Operation

- Storage: NUM_ROWS registers of NUM_COLS bits.
- FSM states:
  - INIT: writes all-ones to row `init_idx`, one row per cycle, for rows 0..NUM_ROWS-1. After the last row, sets `bricks_left` = NUM_ROWS*NUM_COLS and goes to IDLE.
  - IDLE: if `hit_valid` is high, registers `hit_row`/`hit_col` and goes to LOOKUP.
  - LOOKUP: reads the addressed bit and goes to CLEAR.
  - CLEAR: if the bit is 1, writes 0, decrements `bricks_left` and sets `hit_result`=1; otherwise `hit_result`=0. Pulses `hit_ack` and returns to IDLE.
- Out-of-range request (`hit_row` ≥ NUM_ROWS or `hit_col` ≥ NUM_COLS): still goes through LOOKUP/CLEAR, acks with `hit_result`=0, and changes no state.
- Requester holds `hit_valid` and coordinates stable until `hit_ack`. If `hit_valid` is still high in the cycle after the ack, it is treated as a new request.
- `load_level`:
  - Sampled in any state; it has priority over everything except `rst`.
  - Forces INIT with `init_idx`=0 and zeroes `bricks_left`.
  - If it is sampled in LOOKUP or CLEAR, `hit_ack` pulses in that same cycle with `hit_result`=0 and no storage write.
  - `load_level` during INIT restarts the sweep.
- `bricks`:
  - Registered copy of row `rd_row`.
  - Forced to 0 during INIT, and whenever `rd_row` ≥ NUM_ROWS.
- `bricks_left` never underflows, because a decrement happens only on a live bit.
- `all_clear` = (`bricks_left` == 0) && !`busy`.

## Timing

- Reset values:
  - `hit_ack`, `hit_result`, `bricks`, `bricks_left`, `all_clear`: all 0.
  - `busy` = 1; state INIT, `init_idx` = 0.
  - Storage is undefined until INIT writes it.
- Reset mid-operation drops any pending request without an ack.
- INIT length: the first cycle with `rst` low is row 0. `busy` falls NUM_ROWS cycles after `rst` deasserts, in the same edge that loads `bricks_left`.
- Hit latency: `hit_valid` sampled in IDLE at edge N, LOOKUP at N+1, `hit_ack` high during the cycle after edge N+2.
  - Storage and `bricks_left` update at that same edge N+2.
  - Throughput: one request per 3 cycles.
- `bricks` latency: 1 cycle from `rd_row`, and it reflects writes committed at or before the previous edge. A cleared brick therefore disappears from `bricks` 1 cycle after `hit_ack` rises.
- `rst` and `load_level` together: `rst` wins.

## Configuration

- BRICK_SCORE_EN defined:
  - Adds output `score`, 16 bits.
  - Each destroyed brick adds (NUM_ROWS − row), so row 0 (top) is worth the most.
  - Updated in the same edge as `bricks_left` and saturates at 16'hFFFF.
  - Cleared by `rst` only, so it persists across `load_level`.
- BRICK_SCORE_EN undefined: no `score` port and no score logic.

## Structure

- Shared package (`brick_pkg`):
  - NUM_ROWS/NUM_COLS defaults and the full-field brick count.
  - FSM state encoding: INIT, IDLE, LOOKUP, CLEAR.
  - Score weight function.
- Sub-module `brick_row_mem`: the NUM_ROWS×NUM_COLS register array, with one registered read port, one bit-clear write port and one row-fill write port.
- FSM, counters and optional score logic stay in `brick_map`.

## Test plan

- Reset, then release `rst` → `busy`=1 for 8 cycles. Then `bricks_left`=64, `all_clear`=0, and `rd_row`=3 gives `bricks`=8'hFF one cycle later.
- Hit (2,5) → `hit_ack` 3 cycles after `hit_valid` with `hit_result`=1; `bricks_left`=63; `rd_row`=2 gives 8'hDF.
- Repeat hit (2,5); then hit (9,0) → each acks with `hit_result`=0, and `bricks_left` stays 63.
- Clear all 64 bricks with back-to-back requests, keeping `hit_valid` high → `all_clear` rises with the 64th ack, and the next held request acks with 0.
- Assert `load_level` in LOOKUP → same-cycle `hit_ack` with `hit_result`=0, `busy`=1, and after 8 cycles `bricks_left`=64.
- With BRICK_SCORE_EN defined: hit (0,0) then (7,1) → `score`=8, then 9; `load_level` leaves `score` at 9.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared definitions for the Breakout brick field: default geometry,
// FSM state encoding and the per-row score weight.
package brick_pkg;

  localparam int DEF_NUM_ROWS   = 8;
  localparam int DEF_NUM_COLS   = 8;
  localparam int DEF_NUM_BRICKS = DEF_NUM_ROWS * DEF_NUM_COLS;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_CLEAR  = 2'd3
  } brick_state_e;

  // Top row (row 0) is worth the most: NUM_ROWS - row.
  function automatic logic [15:0] score_weight(input int nrows, input int row);
    return 16'(nrows - row);
  endfunction

endpackage

// File: rtl/brick_row_mem.sv
// Brick alive-bit array: NUM_ROWS rows of NUM_COLS bits with a row-fill write
// port, a single-bit clear port, a bit probe and one registered row read port.
module brick_row_mem
  import brick_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int ROW_AW   = 3,
  parameter int COL_AW   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fill_en_i,
  input  logic [ROW_AW-1:0]   fill_row_i,
  input  logic                clr_en_i,
  input  logic [ROW_AW-1:0]   clr_row_i,
  input  logic [COL_AW-1:0]   clr_col_i,
  input  logic [ROW_AW-1:0]   probe_row_i,
  input  logic [COL_AW-1:0]   probe_col_i,
  output logic                probe_bit_o,
  input  logic                rd_en_i,
  input  logic [ROW_AW-1:0]   rd_row_i,
  output logic [NUM_COLS-1:0] rd_data_o
);

  logic [NUM_COLS-1:0] rows_q [NUM_ROWS];
  logic [NUM_COLS-1:0] rd_data_q;

  // Storage is deliberately not reset; the INIT sweep defines it.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      rows_q[fill_row_i] <= '1;
    end else if (clr_en_i) begin
      rows_q[clr_row_i][clr_col_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_en_i ? rows_q[rd_row_i] : '0;
    end
  end

  assign probe_bit_o = rows_q[probe_row_i][probe_col_i];
  assign rd_data_o   = rd_data_q;

endmodule

// File: rtl/brick_map.sv
// Brick field storage, collision resolution (valid/ack) and live-brick count.
// Optional macro BRICK_SCORE_EN adds a saturating 16-bit score output.
module brick_map
  import brick_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int CNT_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_level,
  input  logic                hit_valid,
  input  logic [3:0]          hit_row,
  input  logic [3:0]          hit_col,
  output logic                hit_ack,
  output logic                hit_result,
  input  logic [3:0]          rd_row,
  output logic [NUM_COLS-1:0] bricks,
  output logic [CNT_W-1:0]    bricks_left,
  output logic                all_clear,
`ifdef BRICK_SCORE_EN
  output logic [15:0]         score,
`endif
  output logic                busy
);

  // Handshake: the requester raises hit_valid with stable hit_row/hit_col and
  // holds them until hit_ack; hit_result is valid only while hit_ack is high.
  // hit_valid still high in the cycle after hit_ack is a fresh request.

  localparam int ROW_AW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_AW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [4:0]        ROW_LIM  = 5'(NUM_ROWS);
  localparam logic [4:0]        COL_LIM  = 5'(NUM_COLS);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_ROWS * NUM_COLS);

  brick_state_e      state_q, state_d;
  logic [ROW_AW-1:0] init_idx_q, init_idx_d;
  logic [ROW_AW-1:0] req_row_q, req_row_d;
  logic [COL_AW-1:0] req_col_q, req_col_d;
  logic              req_ok_q, req_ok_d;
  logic              hit_bit_q, hit_bit_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic              ack_q, ack_d;
  logic              res_q, res_d;

  logic              fill_en, clr_en, probe_bit, rd_en, abort;
  logic              hit_in_range, rd_in_range;

  assign hit_in_range = ({1'b0, hit_row} < ROW_LIM) && ({1'b0, hit_col} < COL_LIM);
  assign rd_in_range  = ({1'b0, rd_row} < ROW_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_level) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:   if (init_idx_q == LAST_ROW) state_d = ST_IDLE;
        ST_IDLE:   if (hit_valid) state_d = ST_LOOKUP;
        ST_LOOKUP: state_d = ST_CLEAR;
        ST_CLEAR:  state_d = ST_IDLE;
        default:   state_d = ST_INIT;
      endcase
    end
  end

  // Datapath next-state; load_level overrides any in-flight work.
  always_comb begin
    init_idx_d = init_idx_q;
    req_row_d  = req_row_q;
    req_col_d  = req_col_q;
    req_ok_d   = req_ok_q;
    hit_bit_d  = hit_bit_q;
    left_d     = left_q;
    ack_d      = 1'b0;
    res_d      = 1'b0;
    fill_en    = 1'b0;
    clr_en     = 1'b0;
    if (load_level) begin
      init_idx_d = '0;
      left_d     = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          fill_en    = 1'b1;
          init_idx_d = init_idx_q + 1'b1;
          if (init_idx_q == LAST_ROW) begin
            init_idx_d = '0;
            left_d     = FULL_CNT;
          end
        end
        ST_IDLE: begin
          if (hit_valid) begin
            req_row_d = hit_row[ROW_AW-1:0];
            req_col_d = hit_col[COL_AW-1:0];
            req_ok_d  = hit_in_range;
          end
        end
        ST_LOOKUP: hit_bit_d = req_ok_q & probe_bit;
        ST_CLEAR: begin
          ack_d = 1'b1;
          res_d = hit_bit_q;
          if (hit_bit_q) begin
            clr_en = 1'b1;
            left_d = left_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx_q <= '0;
      req_row_q  <= '0;
      req_col_q  <= '0;
      req_ok_q   <= 1'b0;
      hit_bit_q  <= 1'b0;
      left_q     <= '0;
      ack_q      <= 1'b0;
      res_q      <= 1'b0;
    end else begin
      init_idx_q <= init_idx_d;
      req_row_q  <= req_row_d;
      req_col_q  <= req_col_d;
      req_ok_q   <= req_ok_d;
      hit_bit_q  <= hit_bit_d;
      left_q     <= left_d;
      ack_q      <= ack_d;
      res_q      <= res_d;
    end
  end

  // A level load arriving mid-request acks it immediately with a miss.
  always_comb begin
    busy       = (state_q == ST_INIT);
    abort      = load_level && !rst && ((state_q == ST_LOOKUP) || (state_q == ST_CLEAR));
    hit_ack    = ack_q | abort;
    hit_result = res_q & ~abort;
    all_clear  = (left_q == '0) && (state_q != ST_INIT);
    rd_en      = rd_in_range && (state_q != ST_INIT);
  end

  assign bricks_left = left_q;

  brick_row_mem #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .ROW_AW   (ROW_AW),
    .COL_AW   (COL_AW)
  ) u_mem (
    .clk         (clk),
    .rst         (rst),
    .fill_en_i   (fill_en),
    .fill_row_i  (init_idx_q),
    .clr_en_i    (clr_en),
    .clr_row_i   (req_row_q),
    .clr_col_i   (req_col_q),
    .probe_row_i (req_row_q),
    .probe_col_i (req_col_q),
    .probe_bit_o (probe_bit),
    .rd_en_i     (rd_en),
    .rd_row_i    (rd_row[ROW_AW-1:0]),
    .rd_data_o   (bricks)
  );

`ifdef BRICK_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score_q} + {1'b0, score_weight(NUM_ROWS, int'(req_row_q))};
    score_d   = score_q;
    if (clr_en) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Only rst clears the score; it survives level loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_brick_map.sv
// Scoreboard bench for brick_map: random and directed collision requests are
// checked against an array model of the brick field. Honors BRICK_SCORE_EN.
module tb_brick_map;

  localparam int NR = 8;
  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       rst, load_level, hit_valid;
  logic [3:0] hit_row, hit_col, rd_row;
  logic       hit_ack, hit_result, all_clear, busy;
  logic [7:0] bricks;
  logic [6:0] bricks_left;
`ifdef BRICK_SCORE_EN
  logic [15:0] score;
`endif

  brick_map dut (
    .clk         (clk),
    .rst         (rst),
    .load_level  (load_level),
    .hit_valid   (hit_valid),
    .hit_row     (hit_row),
    .hit_col     (hit_col),
    .hit_ack     (hit_ack),
    .hit_result  (hit_result),
    .rd_row      (rd_row),
    .bricks      (bricks),
    .bricks_left (bricks_left),
    .all_clear   (all_clear),
`ifdef BRICK_SCORE_EN
    .score       (score),
`endif
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit   alive [NR][NC];
  int   left_m  = 0;
  int   score_m = 0;
  logic [39:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_refill();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) alive[r][c] = 1'b1;
    left_m = NR * NC;
  endtask

  function automatic logic [7:0] model_row(input int r);
    logic [7:0] v = '0;
    if (r < NR)
      for (int c = 0; c < NC; c++) v[c] = alive[r][c];
    return v;
  endfunction

  // ---------------- driver tasks (called at negedge+1) ----------------
  task automatic start_req(input int r, input int c, input bit push);
    bit res;
    hit_valid = 1'b1;
    hit_row   = 4'(r);
    hit_col   = 4'(c);
    if (push) begin
      res = (r < NR) && (c < NC) && alive[r][c];
      if (res) begin
        alive[r][c] = 1'b0;
        left_m--;
        score_m = score_m + (NR - r);
        if (score_m > 65535) score_m = 65535;
      end
      exp_q.push_back({16'(cyc + 3), res, 7'(left_m), 16'(score_m)});
    end
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (hit_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic check_row(input int r);
    rd_row = 4'(r);
    @(negedge clk);
    chk("bricks_row", {24'd0, bricks}, {24'd0, model_row(r)});
    #1;
  endtask

  // Called at the negedge right after the edge that sampled load_level.
  task automatic finish_load();
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_left_zero", {25'd0, bricks_left}, 32'd0);
    #1;
    load_level = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      chk("busy_sweep", {31'd0, busy}, (k < NR) ? 32'd1 : 32'd0);
    end
    #1;
    model_refill();
    chk("refill_left", {25'd0, bricks_left}, 32'(left_m));
    chk("refill_all_clear", {31'd0, all_clear}, 32'd0);
  endtask

  task automatic pulse_load();
    load_level = 1'b1;
    @(negedge clk);
    finish_load();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [39:0] e;
  always @(negedge clk) begin
    if (!rst && hit_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_cycle", 32'(cyc[15:0]), {16'd0, e[39:24]});
        chk("hit_result", {31'd0, hit_result}, {31'd0, e[23]});
        chk("bricks_left", {25'd0, bricks_left}, {25'd0, e[22:16]});
        chk("all_clear", {31'd0, all_clear}, {31'd0, (e[22:16] == 7'd0)});
`ifdef BRICK_SCORE_EN
        chk("score", {16'd0, score}, {16'd0, e[15:0]});
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  int coords[$];
  int tmp, j;

  initial begin
    rst = 1'b1; load_level = 1'b0; hit_valid = 1'b0;
    hit_row = '0; hit_col = '0; rd_row = '0;
    repeat (3) @(negedge clk);
    chk("rst_hit_ack", {31'd0, hit_ack}, 32'd0);
    chk("rst_hit_result", {31'd0, hit_result}, 32'd0);
    chk("rst_bricks", {24'd0, bricks}, 32'd0);
    chk("rst_left", {25'd0, bricks_left}, 32'd0);
    chk("rst_all_clear", {31'd0, all_clear}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
`ifdef BRICK_SCORE_EN
    chk("rst_score", {16'd0, score}, 32'd0);
`endif
    #1 rst = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      chk("init_busy", {31'd0, busy}, (k < NR) ? 32'd1 : 32'd0);
    end
    #1;
    model_refill();
    chk("init_left", {25'd0, bricks_left}, 32'd64);
    chk("init_all_clear", {31'd0, all_clear}, 32'd0);
    check_row(3);

    // Directed hits, repeat and out-of-range.
    start_req(2, 5, 1'b1); wait_ack(); hit_valid = 1'b0;
    check_row(2);
    chk("row2_value", {24'd0, bricks}, 32'hDF);
    start_req(2, 5, 1'b1); wait_ack();
    start_req(9, 0, 1'b1); wait_ack();
    start_req(3, 12, 1'b1); wait_ack(); hit_valid = 1'b0;
    check_row(9);

    // Random requests, sometimes held back-to-back.
    for (int i = 0; i < 40; i++) begin
      start_req($urandom_range(0, 9), $urandom_range(0, 9), 1'b1);
      wait_ack();
      if ($urandom_range(0, 1) == 0) begin
        hit_valid = 1'b0;
        check_row($urandom_range(0, 9));
      end
    end
    hit_valid = 1'b0;
    check_row($urandom_range(0, 7));

    // Refill, then clear every brick in shuffled order with hit_valid held.
    pulse_load();
    coords.delete();
    for (int n = 0; n < NR * NC; n++) coords.push_back(n);
    for (int n = NR * NC - 1; n > 0; n--) begin
      j = $urandom_range(0, n);
      tmp = coords[n]; coords[n] = coords[j]; coords[j] = tmp;
    end
    foreach (coords[n]) begin
      start_req(coords[n] / NC, coords[n] % NC, 1'b1);
      wait_ack();
    end
    start_req($urandom_range(0, 7), $urandom_range(0, 7), 1'b1);
    wait_ack();
    hit_valid = 1'b0;
    chk("cleared_all_clear", {31'd0, all_clear}, 32'd1);
    check_row($urandom_range(0, 7));

    // load_level in LOOKUP aborts with a same-cycle miss ack.
    start_req(1, 1, 1'b0);
    @(negedge clk); #1;
    load_level = 1'b1; hit_valid = 1'b0;
    #1;
    chk("abort_lookup_ack", {31'd0, hit_ack}, 32'd1);
    chk("abort_lookup_result", {31'd0, hit_result}, 32'd0);
    @(negedge clk);
    finish_load();

    // load_level in CLEAR.
    start_req(4, 4, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    load_level = 1'b1; hit_valid = 1'b0;
    #1;
    chk("abort_clear_ack", {31'd0, hit_ack}, 32'd1);
    chk("abort_clear_result", {31'd0, hit_result}, 32'd0);
    @(negedge clk);
    finish_load();
    check_row(4);

    // load_level during INIT restarts the sweep.
    load_level = 1'b1;
    @(negedge clk); #1;
    load_level = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    pulse_load();

    // Score weights and persistence across a level load.
    start_req(0, 0, 1'b1); wait_ack(); hit_valid = 1'b0;
    start_req(7, 1, 1'b1); wait_ack(); hit_valid = 1'b0;
    pulse_load();
`ifdef BRICK_SCORE_EN
    chk("score_persist", {16'd0, score}, 32'(score_m));
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
